// File: rtl/vgg_pe_pkg.sv
// Shared types for the VGG PE weight path: sequencer states, rotation select, kernel size.
package vgg_pe_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} seq_state_t;
    typedef logic [1:0] cal_state_t;
    localparam int KSIZE = 3;
endpackage

// File: rtl/weight_row_buf.sv
// Three-row kernel capture register with beat counter; wr_rows/wr_cnt expose the
// post-write contents so a same-cycle beat can be forwarded into another buffer.
module weight_row_buf
    import vgg_pe_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       ld,
    input  logic [KSIZE*KSIZE*DATA_W-1:0] ld_rows,
    input  logic [1:0]                 ld_cnt,
    input  logic                       wr,
    input  logic [KSIZE*DATA_W-1:0]    row,
    output logic [KSIZE*KSIZE*DATA_W-1:0] rows,
    output logic [1:0]                 cnt,
    output logic [KSIZE*KSIZE*DATA_W-1:0] wr_rows,
    output logic [1:0]                 wr_cnt
);
    localparam int ROW_W = KSIZE*DATA_W;

    always_comb begin
        wr_rows = rows;
        wr_cnt  = cnt;
        if (wr && cnt != 2'(KSIZE)) begin
            for (int k = 0; k < KSIZE; k++)
                if (cnt == 2'(k)) wr_rows[k*ROW_W +: ROW_W] = row;
            wr_cnt = cnt + 2'd1;
        end
    end

    // clr only rewinds the counter; stale rows are overwritten before they are used
    always_ff @(posedge clk) begin
        if (reset) begin
            rows <= '0;
            cnt  <= '0;
        end else if (clr) begin
            cnt  <= '0;
        end else if (ld) begin
            rows <= ld_rows;
            cnt  <= ld_cnt;
        end else begin
            rows <= wr_rows;
            cnt  <= wr_cnt;
        end
    end
endmodule

// File: rtl/weight_row_sequencer.sv
// Loads 3x3 kernels as three row beats and steps the PE rotation select per output row.
// Optional WEIGHT_PRELOAD_EN adds a shadow buffer that fills during RUN for a seamless swap.
module weight_row_sequencer
    import vgg_pe_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int OUT_ROWS    = 224,
    parameter int NUM_KERNELS = 64,
    localparam int KI_W = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [3*DATA_W-1:0]     w_row,
    input  logic                    row_step,
    output logic [9*DATA_W-1:0]     weight_out,
    output logic                    weights_vld,
    output logic [1:0]              cal_state,
    output logic [KI_W-1:0]         kernel_idx,
    output logic                    busy,
    output logic                    done
);
    localparam int RC_W = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;

    seq_state_t      state, state_n;
    logic [KI_W-1:0] kidx_n;
    logic [RC_W-1:0] row_cnt, row_n;
    cal_state_t      cal, cal_n;
    logic            pri_clr, pri_ld, pri_wr;
    logic [1:0]      pri_cnt, pri_wr_cnt, pri_ld_cnt;
    logic [9*DATA_W-1:0] pri_wr_rows, pri_ld_rows;
    logic            last_k, last_row;

    assign last_k   = (kernel_idx == KI_W'(NUM_KERNELS-1));
    assign last_row = (row_cnt == RC_W'(OUT_ROWS-1));

    weight_row_buf #(.DATA_W(DATA_W)) u_pri (
        .clk(clk), .reset(reset), .clr(pri_clr), .ld(pri_ld), .ld_rows(pri_ld_rows),
        .ld_cnt(pri_ld_cnt), .wr(pri_wr), .row(w_row), .rows(weight_out), .cnt(pri_cnt),
        .wr_rows(pri_wr_rows), .wr_cnt(pri_wr_cnt)
    );

`ifdef WEIGHT_PRELOAD_EN
    logic            sh_clr, sh_wr;
    logic [1:0]      sh_cnt, sh_wr_cnt;
    logic [9*DATA_W-1:0] sh_rows, sh_wr_rows;

    // primary takes the shadow's post-write view so a beat landing on the swap edge is kept
    weight_row_buf #(.DATA_W(DATA_W)) u_shadow (
        .clk(clk), .reset(reset), .clr(sh_clr), .ld(1'b0), .ld_rows('0), .ld_cnt(2'd0),
        .wr(sh_wr), .row(w_row), .rows(sh_rows), .cnt(sh_cnt),
        .wr_rows(sh_wr_rows), .wr_cnt(sh_wr_cnt)
    );
    assign pri_ld_rows = sh_wr_rows;
    assign pri_ld_cnt  = sh_wr_cnt;
`else
    assign pri_ld_rows = '0;
    assign pri_ld_cnt  = 2'd0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            kernel_idx <= '0;
            row_cnt    <= '0;
            cal        <= '0;
        end else begin
            state      <= state_n;
            kernel_idx <= kidx_n;
            row_cnt    <= row_n;
            cal        <= cal_n;
        end
    end

    always_comb begin
        state_n = state;
        kidx_n  = kernel_idx;
        row_n   = row_cnt;
        cal_n   = cal;
        pri_clr = 1'b0;
        pri_ld  = 1'b0;
        pri_wr  = 1'b0;
        w_ready = 1'b0;
`ifdef WEIGHT_PRELOAD_EN
        sh_clr  = 1'b0;
        sh_wr   = 1'b0;
`endif
        case (state)
            IDLE: if (start) begin
                state_n = LOAD;
                kidx_n  = '0;
                pri_clr = 1'b1;
`ifdef WEIGHT_PRELOAD_EN
                sh_clr  = 1'b1;
`endif
            end
            LOAD: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    pri_wr = 1'b1;
                    if (pri_cnt == 2'(KSIZE-1)) begin
                        state_n = RUN;
                        row_n   = '0;
                        cal_n   = '0;
                    end
                end
            end
            RUN: begin
`ifdef WEIGHT_PRELOAD_EN
                w_ready = !last_k && (sh_cnt != 2'(KSIZE));
                sh_wr   = w_valid && w_ready;
`endif
                if (row_step) begin
                    cal_n = (cal == 2'd2) ? 2'd0 : cal + 2'd1;
                    row_n = row_cnt + RC_W'(1);
                    if (last_row) begin
                        cal_n = '0;
                        row_n = '0;
                        if (last_k) begin
                            state_n = DONE;
                        end else begin
                            kidx_n  = kernel_idx + KI_W'(1);
                            state_n = LOAD;
`ifdef WEIGHT_PRELOAD_EN
                            pri_ld = 1'b1;
                            sh_clr = 1'b1;
                            if (sh_wr_cnt == 2'(KSIZE)) state_n = RUN;
`else
                            pri_clr = 1'b1;
`endif
                        end
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                kidx_n  = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    assign cal_state   = cal;
    assign weights_vld = (state == RUN);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    logic unused;
    assign unused = ^pri_wr_rows ^ ^pri_wr_cnt;
endmodule

// File: tb/tb_weight_row_sequencer.sv
// Directed bench for weight_row_sequencer with OUT_ROWS=5, NUM_KERNELS=2.
module tb_weight_row_sequencer;
    logic         clk = 1'b0;
    logic         reset, start, w_valid, row_step;
    logic         w_ready, weights_vld, busy, done;
    logic [47:0]  w_row;
    logic [143:0] weight_out;
    logic [1:0]   cal_state;
    logic [0:0]   kernel_idx;
    int checks = 0;
    int failures = 0;

    logic [47:0] k0 [3];
    logic [47:0] k1 [3];
    logic [47:0] k2 [3];
    logic [143:0] k0w, k1w, k2w;
    logic [1:0]  cal_before [5];
    logic [1:0]  cal_after [4];

    weight_row_sequencer #(.DATA_W(16), .OUT_ROWS(5), .NUM_KERNELS(2)) dut (
        .clk(clk), .reset(reset), .start(start), .w_valid(w_valid), .w_ready(w_ready),
        .w_row(w_row), .row_step(row_step), .weight_out(weight_out),
        .weights_vld(weights_vld), .cal_state(cal_state), .kernel_idx(kernel_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic beat(input logic [47:0] r);
        w_valid = 1'b1;
        w_row   = r;
        tick();
        w_valid = 1'b0;
        w_row   = 48'hdead_beef_cafe;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; w_valid = 1'b0; row_step = 1'b0; w_row = '0;
        tick(); tick();
        checks++; if (weight_out !== 144'h0) begin failures++; $display("FAIL reset_weight got=%0h exp=0", weight_out); end
        checks++; if ({weights_vld, w_ready, busy, done} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {weights_vld, w_ready, busy, done}); end
        checks++; if ({cal_state, kernel_idx} !== 3'b000) begin failures++; $display("FAIL reset_cal_kidx got=%b exp=000", {cal_state, kernel_idx}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load();
        start = 1'b1; tick(); start = 1'b0;
        checks++; if ({w_ready, busy, weights_vld} !== 3'b110) begin failures++; $display("FAIL load_entry got=%b exp=110", {w_ready, busy, weights_vld}); end
        for (int i = 0; i < 3; i++) begin
            beat(k0[i]);
            if (i < 2) begin
                checks++; if (weights_vld !== 1'b0) begin failures++; $display("FAIL load_early_vld beat=%0d got=%b exp=0", i, weights_vld); end
            end
        end
        checks++; if (weights_vld !== 1'b1) begin failures++; $display("FAIL load_vld got=%b exp=1", weights_vld); end
        checks++; if (weight_out[47:0] !== 48'h000100020003) begin failures++; $display("FAIL load_row0 got=%0h exp=000100020003", weight_out[47:0]); end
        checks++; if (weight_out !== k0w) begin failures++; $display("FAIL load_kernel got=%0h exp=%0h", weight_out, k0w); end
        checks++; if ({cal_state, kernel_idx} !== 3'b000) begin failures++; $display("FAIL load_cal_kidx got=%b exp=000", {cal_state, kernel_idx}); end
`ifndef WEIGHT_PRELOAD_EN
        checks++; if (w_ready !== 1'b0) begin failures++; $display("FAIL run_wready got=%b exp=0", w_ready); end
`endif
    endtask

    task automatic test_rows();
        for (int i = 0; i < 5; i++) begin
            checks++; if (cal_state !== cal_before[i] || weights_vld !== 1'b1) begin failures++; $display("FAIL rows_cal step=%0d got=%0d/%b exp=%0d/1", i, cal_state, weights_vld, cal_before[i]); end
            row_step = 1'b1; tick(); row_step = 1'b0; tick();
        end
        checks++; if ({weights_vld, w_ready} !== 2'b01) begin failures++; $display("FAIL rows_end_flags got=%b exp=01", {weights_vld, w_ready}); end
        checks++; if ({cal_state, kernel_idx} !== 3'b001) begin failures++; $display("FAIL rows_end_cal_kidx got=%b exp=001", {cal_state, kernel_idx}); end
    endtask

    task automatic test_ignored();
        for (int b = 0; b < 3; b++) begin
            beat(k1[b]);
            if (b == 2) break;
            for (int g = 0; g < 4; g++) begin
                row_step = (g == 1);
                start    = (g == 2);
                tick();
                row_step = 1'b0; start = 1'b0;
                checks++; if ({weights_vld, w_ready, cal_state} !== 4'b0100) begin failures++; $display("FAIL ignored_gap b=%0d g=%0d got=%b exp=0100", b, g, {weights_vld, w_ready, cal_state}); end
            end
        end
        checks++; if (weights_vld !== 1'b1 || kernel_idx !== 1'b1) begin failures++; $display("FAIL ignored_vld got=%b/%b exp=1/1", weights_vld, kernel_idx); end
        checks++; if (weight_out !== k1w) begin failures++; $display("FAIL ignored_kernel got=%0h exp=%0h", weight_out, k1w); end
    endtask

    task automatic test_done();
        row_step = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i < 4) begin
                checks++; if (cal_state !== cal_after[i] || done !== 1'b0) begin failures++; $display("FAIL done_cal step=%0d got=%0d/%b exp=%0d/0", i, cal_state, done, cal_after[i]); end
            end
        end
        row_step = 1'b0;
        checks++; if ({done, busy, weights_vld} !== 3'b110) begin failures++; $display("FAIL done_pulse got=%b exp=110", {done, busy, weights_vld}); end
        tick();
        checks++; if ({done, busy, w_ready, kernel_idx} !== 4'b0000) begin failures++; $display("FAIL done_idle got=%b exp=0000", {done, busy, w_ready, kernel_idx}); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) beat(k0[i]);
        row_step = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        row_step = 1'b0;
        beat(k1[0]); beat(k1[1]);
        reset = 1'b1; tick();
        checks++; if (weight_out !== 144'h0 || {weights_vld, w_ready, busy, done} !== 4'b0000) begin failures++; $display("FAIL midreset_out got=%0h/%b exp=0/0000", weight_out, {weights_vld, w_ready, busy, done}); end
        checks++; if ({cal_state, kernel_idx} !== 3'b000) begin failures++; $display("FAIL midreset_cal_kidx got=%b exp=000", {cal_state, kernel_idx}); end
        reset = 1'b0; tick();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat(k2[i]);
            if (i < 2) begin
                checks++; if (weights_vld !== 1'b0) begin failures++; $display("FAIL reload_early_vld beat=%0d got=%b exp=0", i, weights_vld); end
            end
        end
        checks++; if (weights_vld !== 1'b1 || weight_out !== k2w) begin failures++; $display("FAIL reload_kernel got=%b/%0h exp=1/%0h", weights_vld, weight_out, k2w); end
    endtask

`ifdef WEIGHT_PRELOAD_EN
    task automatic test_preload();
        checks++; if (w_ready !== 1'b1) begin failures++; $display("FAIL pre_wready got=%b exp=1", w_ready); end
        for (int i = 0; i < 3; i++) beat(k1[i]);
        checks++; if (w_ready !== 1'b0 || weight_out !== k2w) begin failures++; $display("FAIL pre_full got=%b/%0h exp=0/%0h", w_ready, weight_out, k2w); end
        row_step = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (weights_vld !== 1'b1) begin failures++; $display("FAIL pre_vld step=%0d got=%b exp=1", i, weights_vld); end
        end
        row_step = 1'b0;
        checks++; if ({cal_state, kernel_idx} !== 3'b001 || weight_out !== k1w) begin failures++; $display("FAIL pre_swap got=%b/%0h exp=001/%0h", {cal_state, kernel_idx}, weight_out, k1w); end
    endtask
`endif

    initial begin
        k0[0] = 48'h000100020003; k0[1] = 48'h000400050006; k0[2] = 48'h000700080009;
        k1[0] = 48'h111122223333; k1[1] = 48'h444455556666; k1[2] = 48'h777788889999;
        k2[0] = 48'hA0A0B0B0C0C0; k2[1] = 48'h0123456789AB; k2[2] = 48'hFEDCBA987654;
        k0w = 144'h000700080009_000400050006_000100020003;
        k1w = 144'h777788889999_444455556666_111122223333;
        k2w = 144'hFEDCBA987654_0123456789AB_A0A0B0B0C0C0;
        cal_before[0] = 2'd0; cal_before[1] = 2'd1; cal_before[2] = 2'd2; cal_before[3] = 2'd0; cal_before[4] = 2'd1;
        cal_after[0] = 2'd1; cal_after[1] = 2'd2; cal_after[2] = 2'd0; cal_after[3] = 2'd1;
        test_reset();
        test_load();
        test_rows();
        test_ignored();
        test_done();
        test_reset_mid();
`ifdef WEIGHT_PRELOAD_EN
        test_preload();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
